oped_v5_core: RTL and testbench

Core of the OpenCPI PCIe endpoint (OPED), with the PCIe hard-IP and DMA engines abstracted into a simple host-side request/stream port. It has three jobs: bridge single-word host control accesses onto an AXI4-Lite master, forward host ingress messages onto an AXI4-Stream master, and return AXI4-Stream slave messages to the host with a byte count. It sits between the PCIe transaction layer and user logic, all on the 125 MHz domain.

---
 rtl/oped_pkg.sv | 30 +++
 rtl/axis_reg_slice.sv | 44 ++++
 rtl/oped_v5_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_oped_v5_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oped_pkg.sv
// Shared types and constants for the OPED core: control FSM encoding,
// AXI-Stream TUSER field layout, AXI response codes and debug word layout.
package oped_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4,
    ST_RSP  = 3'd5
  } ctl_state_e;

  localparam int TUSER_LEN_LSB = 16;
  localparam int TUSER_LEN_W   = 16;
  localparam int TUSER_OPC_LSB = 0;
  localparam int TUSER_OPC_W   = 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int DBG_CTL_LSB = 24;
  localparam int DBG_IN_LSB  = 16;
  localparam int DBG_OUT_LSB = 8;
  localparam int DBG_ERR_BIT = 3;

  function automatic logic [15:0] popcount4(input logic [3:0] s);
    return 16'(s[0]) + 16'(s[1]) + 16'(s[2]) + 16'(s[3]);
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage valid/ready register slice; full throughput when downstream is
// always ready. Ready is forced low while reset is asserted.
module axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = rst_n_i & (~valid_q | out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/oped_v5_core.sv
// OPED core: host control accesses bridged to AXI4-Lite, host ingress to
// AXI4-Stream master, AXI4-Stream slave back to host egress with byte count.
//
// state | meaning
// IDLE  | ready for a host control request
// WR    | AW and W channels outstanding
// WB    | waiting for write response
// RA    | AR channel outstanding
// RD    | waiting for read data
// RSP   | presenting response to host
module oped_v5_core
  import oped_pkg::*;
(
  input  logic        p125clk,
  input  logic        RST_N_p125rst,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_write,
  input  logic [31:0] host_req_addr,
  input  logic [31:0] host_req_data,
  input  logic [3:0]  host_req_strb,
  output logic        host_rsp_valid,
  input  logic        host_rsp_ready,
  output logic [31:0] host_rsp_data,
  output logic        host_rsp_err,
  output logic [31:0] axi4m_AWADDR,
  output logic [2:0]  axi4m_AWPROT,
  output logic        axi4m_AWVALID,
  input  logic        axi4m_AWREADY,
  output logic [31:0] axi4m_WDATA,
  output logic [3:0]  axi4m_WSTRB,
  output logic        axi4m_WVALID,
  input  logic        axi4m_WREADY,
  input  logic [1:0]  axi4m_BRESP,
  input  logic        axi4m_BVALID,
  output logic        axi4m_BREADY,
  output logic [31:0] axi4m_ARADDR,
  output logic [2:0]  axi4m_ARPROT,
  output logic        axi4m_ARVALID,
  input  logic        axi4m_ARREADY,
  input  logic [31:0] axi4m_RDATA,
  input  logic [1:0]  axi4m_RRESP,
  input  logic        axi4m_RVALID,
  output logic        axi4m_RREADY,
  input  logic [31:0] host_in_data,
  input  logic [7:0]  host_in_opcode,
  input  logic [15:0] host_in_len,
  input  logic        host_in_last,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [31:0] axisM_TDATA,
  output logic [3:0]  axisM_TSTRB,
  output logic [31:0] axisM_TUSER,
  output logic        axisM_TLAST,
  output logic        axisM_TVALID,
  input  logic        axisM_TREADY,
  input  logic [31:0] axisS_TDATA,
  input  logic [3:0]  axisS_TSTRB,
  input  logic [31:0] axisS_TUSER,
  input  logic        axisS_TLAST,
  input  logic        axisS_TVALID,
  output logic        axisS_TREADY,
  output logic [31:0] host_out_data,
  output logic [7:0]  host_out_opcode,
  output logic [15:0] host_out_len,
  output logic        host_out_last,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic [31:0] debug
);

  ctl_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  cnt_ctl_q, cnt_ctl_d;
  logic [7:0]  cnt_in_q, cnt_out_q;

  assign host_req_ready = RST_N_p125rst & (state_q == ST_IDLE);
  assign host_rsp_valid = (state_q == ST_RSP);
  assign host_rsp_data  = rsp_data_q;
  assign host_rsp_err   = rsp_err_q;
  assign axi4m_AWADDR   = addr_q;
  assign axi4m_AWPROT   = 3'b000;
  assign axi4m_AWVALID  = (state_q == ST_WR) & aw_pend_q;
  assign axi4m_WDATA    = wdata_q;
  assign axi4m_WSTRB    = strb_q;
  assign axi4m_WVALID   = (state_q == ST_WR) & w_pend_q;
  assign axi4m_BREADY   = (state_q == ST_WB);
  assign axi4m_ARADDR   = addr_q;
  assign axi4m_ARPROT   = 3'b000;
  assign axi4m_ARVALID  = (state_q == ST_RA);
  assign axi4m_RREADY   = (state_q == ST_RD);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    sticky_d   = sticky_q;
    cnt_ctl_d  = cnt_ctl_q;
    case (state_q)
      ST_IDLE: begin
        if (host_req_valid) begin
          addr_d    = host_req_addr;
          wdata_d   = host_req_data;
          strb_d    = host_req_strb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = host_req_write ? ST_WR : ST_RA;
        end
      end
      ST_WR: begin
        if (aw_pend_q && axi4m_AWREADY) aw_pend_d = 1'b0;
        if (w_pend_q && axi4m_WREADY)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)    state_d   = ST_WB;
      end
      ST_WB: begin
        if (axi4m_BVALID) begin
          rsp_data_d = '0;
          rsp_err_d  = (axi4m_BRESP != AXI_RESP_OKAY);
          sticky_d   = sticky_q | (axi4m_BRESP != AXI_RESP_OKAY);
          state_d    = ST_RSP;
        end
      end
      ST_RA: begin
        if (axi4m_ARREADY) state_d = ST_RD;
      end
      ST_RD: begin
        if (axi4m_RVALID) begin
          rsp_data_d = axi4m_RDATA;
          rsp_err_d  = (axi4m_RRESP != AXI_RESP_OKAY);
          sticky_d   = sticky_q | (axi4m_RRESP != AXI_RESP_OKAY);
          state_d    = ST_RSP;
        end
      end
      ST_RSP: begin
        if (host_rsp_ready) begin
          cnt_ctl_d = cnt_ctl_q + 8'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge p125clk or negedge RST_N_p125rst) begin
    if (!RST_N_p125rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_ctl_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      sticky_q   <= sticky_d;
      cnt_ctl_q  <= cnt_ctl_d;
    end
  end

  // Ingress: TSTRB rides in the payload so it reads 0 while the slice is reset.
  logic [31:0] ing_tuser;
  logic [68:0] ing_pl_in, ing_pl_out;

  always_comb begin
    ing_tuser = '0;
    ing_tuser[TUSER_LEN_LSB +: TUSER_LEN_W] = host_in_len;
    ing_tuser[TUSER_OPC_LSB +: TUSER_OPC_W] = host_in_opcode;
  end

  assign ing_pl_in = {host_in_data, ing_tuser, 4'hF, host_in_last};

  axis_reg_slice #(.W(69)) u_ing_slice (
    .clk_i       (p125clk),
    .rst_n_i     (RST_N_p125rst),
    .in_data_i   (ing_pl_in),
    .in_valid_i  (host_in_valid),
    .in_ready_o  (host_in_ready),
    .out_data_o  (ing_pl_out),
    .out_valid_o (axisM_TVALID),
    .out_ready_i (axisM_TREADY)
  );

  assign {axisM_TDATA, axisM_TUSER, axisM_TSTRB, axisM_TLAST} = ing_pl_out;

  // Egress: byte count and opcode are resolved before the slice so they
  // travel with the beat they describe.
  logic        eg_first_q, eg_first_d;
  logic [7:0]  eg_opc_q, eg_opc_d;
  logic [15:0] eg_cnt_q, eg_cnt_d;
  logic [7:0]  eg_opc_in;
  logic [15:0] eg_len_in;
  logic [56:0] eg_pl_in, eg_pl_out;
  logic        eg_hs;
  logic        unused_tuser;

  assign unused_tuser = ^axisS_TUSER[31:TUSER_OPC_W];
  assign eg_opc_in    = eg_first_q ? axisS_TUSER[TUSER_OPC_LSB +: TUSER_OPC_W] : eg_opc_q;
  assign eg_len_in    = eg_cnt_q + popcount4(axisS_TSTRB);
  assign eg_hs        = axisS_TVALID & axisS_TREADY;
  assign eg_pl_in     = {axisS_TDATA, eg_opc_in, eg_len_in, axisS_TLAST};

  always_comb begin
    eg_first_d = eg_first_q;
    eg_opc_d   = eg_opc_q;
    eg_cnt_d   = eg_cnt_q;
    if (eg_hs) begin
      eg_opc_d = eg_opc_in;
      if (axisS_TLAST) begin
        eg_first_d = 1'b1;
        eg_cnt_d   = '0;
      end else begin
        eg_first_d = 1'b0;
        eg_cnt_d   = eg_len_in;
      end
    end
  end

  always_ff @(posedge p125clk or negedge RST_N_p125rst) begin
    if (!RST_N_p125rst) begin
      eg_first_q <= 1'b1;
      eg_opc_q   <= '0;
      eg_cnt_q   <= '0;
    end else begin
      eg_first_q <= eg_first_d;
      eg_opc_q   <= eg_opc_d;
      eg_cnt_q   <= eg_cnt_d;
    end
  end

  axis_reg_slice #(.W(57)) u_eg_slice (
    .clk_i       (p125clk),
    .rst_n_i     (RST_N_p125rst),
    .in_data_i   (eg_pl_in),
    .in_valid_i  (axisS_TVALID),
    .in_ready_o  (axisS_TREADY),
    .out_data_o  (eg_pl_out),
    .out_valid_o (host_out_valid),
    .out_ready_i (host_out_ready)
  );

  assign {host_out_data, host_out_opcode, host_out_len, host_out_last} = eg_pl_out;

  always_ff @(posedge p125clk or negedge RST_N_p125rst) begin
    if (!RST_N_p125rst) begin
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      if (axisM_TVALID && axisM_TREADY && axisM_TLAST)     cnt_in_q  <= cnt_in_q + 8'd1;
      if (host_out_valid && host_out_ready && host_out_last) cnt_out_q <= cnt_out_q + 8'd1;
    end
  end

  always_comb begin
    debug = '0;
    debug[DBG_CTL_LSB +: 8] = cnt_ctl_q;
    debug[DBG_IN_LSB +: 8]  = cnt_in_q;
    debug[DBG_OUT_LSB +: 8] = cnt_out_q;
    debug[DBG_ERR_BIT]      = sticky_q;
    debug[2:0]              = state_q;
  end

endmodule

// File: tb/tb_oped_v5_core.sv
// Directed bench for oped_v5_core: control write/read bridging, AXI stalls,
// ingress/egress slices with backpressure, and asynchronous reset.
module tb_oped_v5_core;

  logic        p125clk = 1'b0;
  logic        RST_N_p125rst;
  logic        host_req_valid, host_req_ready, host_req_write;
  logic [31:0] host_req_addr, host_req_data;
  logic [3:0]  host_req_strb;
  logic        host_rsp_valid, host_rsp_ready, host_rsp_err;
  logic [31:0] host_rsp_data;
  logic [31:0] axi4m_AWADDR, axi4m_WDATA, axi4m_ARADDR, axi4m_RDATA;
  logic [2:0]  axi4m_AWPROT, axi4m_ARPROT;
  logic        axi4m_AWVALID, axi4m_AWREADY, axi4m_WVALID, axi4m_WREADY;
  logic [3:0]  axi4m_WSTRB;
  logic [1:0]  axi4m_BRESP, axi4m_RRESP;
  logic        axi4m_BVALID, axi4m_BREADY, axi4m_ARVALID, axi4m_ARREADY;
  logic        axi4m_RVALID, axi4m_RREADY;
  logic [31:0] host_in_data;
  logic [7:0]  host_in_opcode;
  logic [15:0] host_in_len;
  logic        host_in_last, host_in_valid, host_in_ready;
  logic [31:0] axisM_TDATA, axisM_TUSER;
  logic [3:0]  axisM_TSTRB;
  logic        axisM_TLAST, axisM_TVALID, axisM_TREADY;
  logic [31:0] axisS_TDATA, axisS_TUSER;
  logic [3:0]  axisS_TSTRB;
  logic        axisS_TLAST, axisS_TVALID, axisS_TREADY;
  logic [31:0] host_out_data;
  logic [7:0]  host_out_opcode;
  logic [15:0] host_out_len;
  logic        host_out_last, host_out_valid, host_out_ready;
  logic [31:0] debug;

  int n_cmp = 0;
  int n_err = 0;

  always #5 p125clk = ~p125clk;

  oped_v5_core dut (
    .p125clk(p125clk), .RST_N_p125rst(RST_N_p125rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_write(host_req_write), .host_req_addr(host_req_addr),
    .host_req_data(host_req_data), .host_req_strb(host_req_strb),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
    .axi4m_AWADDR(axi4m_AWADDR), .axi4m_AWPROT(axi4m_AWPROT),
    .axi4m_AWVALID(axi4m_AWVALID), .axi4m_AWREADY(axi4m_AWREADY),
    .axi4m_WDATA(axi4m_WDATA), .axi4m_WSTRB(axi4m_WSTRB),
    .axi4m_WVALID(axi4m_WVALID), .axi4m_WREADY(axi4m_WREADY),
    .axi4m_BRESP(axi4m_BRESP), .axi4m_BVALID(axi4m_BVALID), .axi4m_BREADY(axi4m_BREADY),
    .axi4m_ARADDR(axi4m_ARADDR), .axi4m_ARPROT(axi4m_ARPROT),
    .axi4m_ARVALID(axi4m_ARVALID), .axi4m_ARREADY(axi4m_ARREADY),
    .axi4m_RDATA(axi4m_RDATA), .axi4m_RRESP(axi4m_RRESP),
    .axi4m_RVALID(axi4m_RVALID), .axi4m_RREADY(axi4m_RREADY),
    .host_in_data(host_in_data), .host_in_opcode(host_in_opcode),
    .host_in_len(host_in_len), .host_in_last(host_in_last),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .axisM_TDATA(axisM_TDATA), .axisM_TSTRB(axisM_TSTRB), .axisM_TUSER(axisM_TUSER),
    .axisM_TLAST(axisM_TLAST), .axisM_TVALID(axisM_TVALID), .axisM_TREADY(axisM_TREADY),
    .axisS_TDATA(axisS_TDATA), .axisS_TSTRB(axisS_TSTRB), .axisS_TUSER(axisS_TUSER),
    .axisS_TLAST(axisS_TLAST), .axisS_TVALID(axisS_TVALID), .axisS_TREADY(axisS_TREADY),
    .host_out_data(host_out_data), .host_out_opcode(host_out_opcode),
    .host_out_len(host_out_len), .host_out_last(host_out_last),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .debug(debug)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] eg_data [4] = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
  logic [3:0]  eg_strb [4] = '{4'hF, 4'hF, 4'h3, 4'h1};
  logic [31:0] eg_user [4] = '{32'hABCD_0042, 32'hABCD_0077, 32'hABCD_0077, 32'hABCD_0011};
  logic        eg_last [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] eg_xlen [4] = '{16'd4, 16'd8, 16'd10, 16'd1};
  logic [7:0]  eg_xopc [4] = '{8'h42, 8'h42, 8'h42, 8'h11};

  initial begin
    int idx, n_out;
    logic hs;
    RST_N_p125rst = 1'b0;
    host_req_valid = 0; host_req_write = 0; host_req_addr = '0; host_req_data = '0;
    host_req_strb = '0; host_rsp_ready = 0;
    axi4m_AWREADY = 0; axi4m_WREADY = 0; axi4m_BRESP = '0; axi4m_BVALID = 0;
    axi4m_ARREADY = 0; axi4m_RDATA = '0; axi4m_RRESP = '0; axi4m_RVALID = 0;
    host_in_data = '0; host_in_opcode = '0; host_in_len = '0; host_in_last = 0; host_in_valid = 0;
    axisM_TREADY = 0;
    axisS_TDATA = '0; axisS_TSTRB = '0; axisS_TUSER = '0; axisS_TLAST = 0; axisS_TVALID = 0;
    host_out_ready = 0;

    // reset state
    repeat (2) @(negedge p125clk);
    chk("rst_req_ready", host_req_ready, 0);
    chk("rst_in_ready", host_in_ready, 0);
    chk("rst_tready", axisS_TREADY, 0);
    chk("rst_debug", debug, 0);
    RST_N_p125rst = 1'b1;
    @(negedge p125clk);
    chk("idle_req_ready", host_req_ready, 1);

    // zero-wait write, BVALID held high early to show it is ignored outside WB
    host_req_valid = 1; host_req_write = 1; host_req_addr = 32'h10;
    host_req_data = 32'hDEADBEEF; host_req_strb = 4'hF;
    axi4m_AWREADY = 1; axi4m_WREADY = 1; axi4m_BVALID = 1; axi4m_BRESP = 2'b00;
    @(negedge p125clk);
    host_req_valid = 0;
    chk("wr_awvalid", axi4m_AWVALID, 1);
    chk("wr_wvalid", axi4m_WVALID, 1);
    chk("wr_awaddr", axi4m_AWADDR, 32'h10);
    chk("wr_wdata", axi4m_WDATA, 32'hDEADBEEF);
    chk("wr_wstrb", axi4m_WSTRB, 4'hF);
    chk("wr_awprot", axi4m_AWPROT, 0);
    chk("wr_bready_early", axi4m_BREADY, 0);
    chk("wr_state", debug[2:0], 1);
    @(negedge p125clk);
    chk("wb_bready", axi4m_BREADY, 1);
    chk("wb_awvalid", axi4m_AWVALID, 0);
    chk("wb_rsp_valid", host_rsp_valid, 0);
    @(negedge p125clk);
    chk("wr_rsp_valid", host_rsp_valid, 1);
    chk("wr_rsp_data", host_rsp_data, 0);
    chk("wr_rsp_err", host_rsp_err, 0);
    axi4m_BVALID = 0; host_rsp_ready = 1;
    @(negedge p125clk);
    host_rsp_ready = 0;
    chk("wr_rsp_done", host_rsp_valid, 0);
    chk("wr_dbg_ctl", debug[31:24], 1);
    chk("wr_dbg_err", debug[3], 0);

    // read with AR stall and 3 RD wait cycles, SLVERR response
    host_req_valid = 1; host_req_write = 0; host_req_addr = 32'h20;
    axi4m_AWREADY = 0; axi4m_WREADY = 0; axi4m_ARREADY = 0;
    @(negedge p125clk);
    host_req_valid = 0;
    chk("rd_arvalid", axi4m_ARVALID, 1);
    chk("rd_araddr", axi4m_ARADDR, 32'h20);
    chk("rd_arprot", axi4m_ARPROT, 0);
    chk("rd_state_ra", debug[2:0], 3);
    axi4m_ARREADY = 1;
    @(negedge p125clk);
    axi4m_ARREADY = 0;
    chk("rd_arvalid_off", axi4m_ARVALID, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rd_rready", axi4m_RREADY, 1);
      chk("rd_no_rsp", host_rsp_valid, 0);
      if (i == 2) begin
        axi4m_RVALID = 1; axi4m_RDATA = 32'h12345678; axi4m_RRESP = 2'b10;
      end
      @(negedge p125clk);
    end
    chk("rd_rsp_valid", host_rsp_valid, 1);
    chk("rd_rsp_data", host_rsp_data, 32'h12345678);
    chk("rd_rsp_err", host_rsp_err, 1);
    chk("rd_dbg_err", debug[3], 1);
    chk("rd_state_rsp", debug[2:0], 5);
    axi4m_RVALID = 0; host_rsp_ready = 1;
    @(negedge p125clk);
    host_rsp_ready = 0;
    chk("rd_dbg_ctl", debug[31:24], 2);

    // write with AWREADY delayed two cycles, WREADY immediate
    host_req_valid = 1; host_req_write = 1; host_req_addr = 32'h44;
    host_req_data = 32'h0000_1234; host_req_strb = 4'h3;
    axi4m_AWREADY = 0; axi4m_WREADY = 1;
    @(negedge p125clk);
    host_req_valid = 0;
    chk("dly_aw_c1", axi4m_AWVALID, 1);
    chk("dly_w_c1", axi4m_WVALID, 1);
    chk("dly_wstrb", axi4m_WSTRB, 4'h3);
    @(negedge p125clk);
    chk("dly_aw_c2", axi4m_AWVALID, 1);
    chk("dly_w_c2", axi4m_WVALID, 0);
    @(negedge p125clk);
    chk("dly_aw_c3", axi4m_AWVALID, 1);
    chk("dly_state_c3", debug[2:0], 1);
    axi4m_AWREADY = 1;
    @(negedge p125clk);
    axi4m_AWREADY = 0;
    chk("dly_aw_c4", axi4m_AWVALID, 0);
    chk("dly_bready", axi4m_BREADY, 1);
    axi4m_BVALID = 1;
    @(negedge p125clk);
    axi4m_BVALID = 0;
    chk("dly_rsp_valid", host_rsp_valid, 1);
    chk("dly_rsp_err", host_rsp_err, 0);
    host_rsp_ready = 1;
    @(negedge p125clk);
    chk("dly_rsp_done", host_rsp_valid, 0);
    @(negedge p125clk);
    host_rsp_ready = 0;
    chk("dly_single_rsp", host_rsp_valid, 0);
    chk("dly_dbg_ctl", debug[31:24], 3);
    chk("dly_dbg_sticky", debug[3], 1);

    // ingress: 3 beats, TREADY toggling
    idx = 0; n_out = 0; hs = 0;
    for (int cyc = 0; cyc < 40 && n_out < 3; cyc++) begin
      @(negedge p125clk);
      if (hs) idx++;
      host_in_valid  = (idx < 3);
      host_in_data   = 32'hA000_0001 + idx;
      host_in_opcode = 8'h05;
      host_in_len    = 16'd12;
      host_in_last   = (idx == 2);
      axisM_TREADY   = cyc[0];
      #1;
      hs = host_in_valid & host_in_ready;
      if (axisM_TVALID && axisM_TREADY) begin
        chk("ing_tdata", axisM_TDATA, 32'hA000_0001 + n_out);
        chk("ing_tuser", axisM_TUSER, 32'h000C_0005);
        chk("ing_tstrb", axisM_TSTRB, 4'hF);
        chk("ing_tlast", axisM_TLAST, (n_out == 2));
        n_out++;
      end
    end
    chk("ing_beats", n_out, 3);
    host_in_valid = 0;
    @(negedge p125clk);
    axisM_TREADY = 1;
    chk("ing_no_dup", axisM_TVALID, 0);
    chk("ing_dbg_in", debug[23:16], 1);

    // egress: one 3-beat message then a 1-beat message
    idx = 0; n_out = 0; hs = 0;
    for (int cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
      @(negedge p125clk);
      if (hs) idx++;
      axisS_TVALID = (idx < 4);
      if (idx < 4) begin
        axisS_TDATA = eg_data[idx];
        axisS_TSTRB = eg_strb[idx];
        axisS_TUSER = eg_user[idx];
        axisS_TLAST = eg_last[idx];
      end
      host_out_ready = ((cyc % 3) != 1);
      #1;
      hs = axisS_TVALID & axisS_TREADY;
      if (host_out_valid && host_out_ready) begin
        chk("eg_data", host_out_data, eg_data[n_out]);
        chk("eg_len", host_out_len, eg_xlen[n_out]);
        chk("eg_opcode", host_out_opcode, eg_xopc[n_out]);
        chk("eg_last", host_out_last, eg_last[n_out]);
        n_out++;
      end
    end
    chk("eg_beats", n_out, 4);
    axisS_TVALID = 0;
    @(negedge p125clk);
    chk("eg_no_dup", host_out_valid, 0);
    chk("eg_dbg_out", debug[15:8], 2);

    // asynchronous reset in the middle of a write
    host_req_valid = 1; host_req_write = 1; host_req_addr = 32'h80;
    host_req_data = 32'h5555_AAAA; host_req_strb = 4'hF;
    axi4m_AWREADY = 0; axi4m_WREADY = 0;
    @(negedge p125clk);
    host_req_valid = 0;
    chk("mid_awvalid", axi4m_AWVALID, 1);
    #2 RST_N_p125rst = 1'b0;
    #1;
    chk("arst_awvalid", axi4m_AWVALID, 0);
    chk("arst_wvalid", axi4m_WVALID, 0);
    chk("arst_awaddr", axi4m_AWADDR, 0);
    chk("arst_wdata", axi4m_WDATA, 0);
    chk("arst_req_ready", host_req_ready, 0);
    chk("arst_in_ready", host_in_ready, 0);
    chk("arst_tready", axisS_TREADY, 0);
    chk("arst_debug", debug, 0);
    repeat (2) @(negedge p125clk);
    RST_N_p125rst = 1'b1;
    @(negedge p125clk);
    chk("post_req_ready", host_req_ready, 1);
    chk("post_debug", debug, 0);
    chk("post_awvalid", axi4m_AWVALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
